scancode_to_matrix: RTL and testbench
=====================================

SCANCODE_TO_MATRIX -- requirements
Module: scancode_to_matrix

Interface
REQ-001 Parameter SLOTS, default 2: matrix keys driven per scancode; 2 or 4 only.
REQ-002 Parameter ROWS, default 8: matrix half-rows; range 1..8.
REQ-003 Parameter COLS, default 5: columns per half-row; range 1..5.
REQ-004 Parameter CNT_W, default 2: width of the per-position press reference counter.
REQ-005 clk  input  1  clock, same domain as PS/2 decoder.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 scan_received  input  1  one-cycle strobe; scan, extended, released and modifiers are valid.
REQ-008 scan  input  7  scancode.
REQ-009 extended  input  1  E0-prefixed scancode.
REQ-010 released  input  1  break code.
REQ-011 modifiers  input  3  {alt,ctrl,shift} live state.
REQ-012 clear_all  input  1  one-cycle strobe; release every key.
REQ-013 sp_row  input  ROWS  active-low half-row select.
REQ-014 sp_col  output  COLS  active-low column data, combinational.
REQ-015 din  input  8  CPU keymap write data.
REQ-016 dout  output  8  CPU keymap read data.
REQ-017 cpuread, cpuwrite, rewind  input  1 each  CPU keymap access strobes (level).
REQ-018 scan_dropped  output  1  one-cycle pulse; a scancode was lost.

Function
REQ-019 Keymap: SLOTS tables of 2048x8, address {mod[2:0],extended,scan}; entry {row[2:0],colmask[4:0]}; colmask 0 or row>=ROWS = no key.
REQ-020 Each matrix position keeps an unsigned CNT_W counter; position reads 0 on sp_col while counter is nonzero.
REQ-021 sp_col = bitwise AND of half-rows whose sp_row bit is 0; all ones when none selected.
REQ-022 Press table: 256 entries {valid, mod[2:0]} indexed {extended,scan}.
REQ-023 Press with valid=0: store modifiers, set valid, increment counters of every key in every slot; increments saturate at 2^CNT_W-1.
REQ-024 Press with valid=1 (typematic repeat): no matrix change.
REQ-025 Release with valid=1: look up with stored modifiers (not live), decrement same counters (floor 0), clear valid.
REQ-026 Release with valid=0: ignored.
REQ-027 FSM states: IDLE, LOOKUP, APPLY (SLOTS cycles, one slot each), CLEAR, CPUTIME, CPUREAD, CPUWRITE, CPUINCADD.
REQ-028 Latency: strobe at cycle 0 with FSM in IDLE, final counter update visible on sp_col at cycle 2+SLOTS.
REQ-029 One-deep pending latch: a strobe with latch full pulses scan_dropped and discards the new code.
REQ-030 Priority in IDLE: clear_all > pending scancode > rewind > cpuread/cpuwrite.
REQ-031 CLEAR: all counters and valid bits zeroed in one cycle; next state IDLE; pending latch kept.
REQ-032 CPU address cpuaddr, 11+log2(SLOTS) bits = {entry[10:0],slot}; rewind zeroes it.
REQ-033 CPUREAD loads dout from table slot; CPUWRITE writes din to table slot; CPUINCADD waits both strobes low, increments cpuaddr with wrap to 0, returns to IDLE.
REQ-034 CPU access never stalls scancode capture; the scancode is processed after CPUINCADD.

Reset
REQ-035 rst: state IDLE, counters 0, valid bits 0, pending latch empty, cpuaddr 0, dout 0x00, scan_dropped 0, sp_col all ones; keymap contents unchanged.

Configuration
REQ-036 Macro SCANMATRIX_CPU_ACCESS_EN defined: REQ-032/033 active, keymap is RAM.
REQ-037 Macro undefined: keymap is ROM from init files, CPU states absent, dout tied 0x00, strobes ignored.

Structure
REQ-038 Package scanmatrix_pkg: entry field widths, FSM state encoding, keymap address layout constants.
REQ-039 Sub-module scanmatrix_refcnt: one per-position saturating up/down counter with nonzero output, instanced ROWSxCOLS.

Verification
REQ-040 Press 0x1C (map slot0=row1 col0, slot1 none) -> cycle 4: sp_row=0xFD gives sp_col=0x1E; release -> 0x1F.
REQ-041 Press shift, press 0x16 (shifted entry), release shift, release 0x16 -> all keys clear; no stuck key.
REQ-042 Two scancodes both mapping row0 col0; release one -> still pressed; release other -> released.
REQ-043 Three strobes on consecutive cycles -> third pulses scan_dropped; first two applied.
REQ-044 rewind, write 0xA5 at cpuaddr 3, rewind, read three times then once more -> fourth read dout=0xA5, cpuaddr=4.
REQ-045 Repeat make 0x1C x5, single break -> key released; clear_all mid-APPLY -> all ones after CLEAR.

Source files
------------

// File: rtl/scanmatrix_pkg.sv
// scanmatrix_pkg: shared definitions for the scancode-to-matrix translator.
//   - keymap entry layout {row[2:0], colmask[4:0]} and keymap address layout
//     {mods[2:0], extended, scan[6:0]}
//   - FSM state encoding and counter action encoding
//   - keymap_rom(): built-in keymap used when SCANMATRIX_CPU_ACCESS_EN is
//     undefined (slot-major, one 2048x8 table per slot)
package scanmatrix_pkg;

    localparam int SCAN_W       = 7;
    localparam int MOD_W        = 3;
    localparam int ROW_W        = 3;
    localparam int COLMASK_W    = 5;
    localparam int ENTRY_W      = ROW_W + COLMASK_W;
    localparam int KEYMAP_AW    = MOD_W + 1 + SCAN_W;
    localparam int KEYMAP_DEPTH = 2048;
    localparam int PRESS_AW     = 1 + SCAN_W;
    localparam int PRESS_DEPTH  = 256;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOOKUP    = 3'd1,
        ST_APPLY     = 3'd2,
        ST_CLEAR     = 3'd3,
        ST_CPUTIME   = 3'd4,
        ST_CPUREAD   = 3'd5,
        ST_CPUWRITE  = 3'd6,
        ST_CPUINCADD = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        ACT_NONE = 2'd0,
        ACT_INC  = 2'd1,
        ACT_DEC  = 2'd2
    } act_t;

    typedef struct packed {
        logic [MOD_W-1:0]  mods;
        logic              ext;
        logic              rel;
        logic [SCAN_W-1:0] scan;
    } scan_code_t;

    typedef struct packed {
        logic             valid;
        logic [MOD_W-1:0] mods;
    } press_ent_t;

    // Built-in keymap; unlisted addresses map to no key (entry 0x00).
    function automatic logic [ENTRY_W-1:0] keymap_rom(input logic [1:0] slot,
                                                      input logic [KEYMAP_AW-1:0] addr);
        logic [ENTRY_W-1:0] ent;
        ent = 8'h00;
        case ({slot, addr})
            13'h001C: ent = 8'h21;  // 0x1C            -> row1 col0
            13'h001A: ent = 8'h01;  // 0x1A            -> row0 col0
            13'h0022: ent = 8'h01;  // 0x22            -> row0 col0
            13'h0021: ent = 8'h01;  // 0x21            -> row0 col0
            13'h0023: ent = 8'h01;  // 0x23            -> row0 col0
            13'h0016: ent = 8'h64;  // 0x16            -> row3 col2
            13'h0116: ent = 8'h42;  // shift+0x16      -> row2 col1
            13'h0015: ent = 8'h8C;  // 0x15            -> row4 col2+col3
            13'h009C: ent = 8'hF0;  // E0 0x1C         -> row7 col4
            13'h0815: ent = 8'hA1;  // slot1 0x15      -> row5 col0
            13'h0916: ent = 8'h10;  // slot1 shift+0x16 -> row0 col4
            default:  ent = 8'h00;
        endcase
        return ent;
    endfunction

endpackage

// File: rtl/scanmatrix_refcnt.sv
// scanmatrix_refcnt: reference counter for one matrix position.
//   clk, rst  : clock, synchronous active-high reset
//   clr       : synchronous clear to zero (clear_all handling)
//   inc, dec  : count up (saturating at all ones) / down (floor at zero)
//   nonzero   : position is held down by at least one scancode
module scanmatrix_refcnt #(
    parameter int CNT_W = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    input  logic dec,
    output logic nonzero
);

    logic [CNT_W-1:0] cnt_r;

    // Saturating up/down reference count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (inc && !dec && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else if (dec && !inc && (cnt_r != {CNT_W{1'b0}})) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign nonzero = |cnt_r;

endmodule

// File: rtl/scancode_to_matrix.sv
// scancode_to_matrix: turns PS/2 make/break scancodes into a reference-counted
// keyboard matrix that a host scans with active-low half-row selects.
//   clk, rst           : clock, synchronous active-high reset
//   scan_received      : strobe; scan/extended/released/modifiers valid
//   clear_all          : strobe; release every key
//   sp_row / sp_col    : active-low row select in, active-low column data out
//   din, dout          : CPU keymap write / read data
//   cpuread, cpuwrite, rewind : CPU keymap access levels
//   scan_dropped       : pulse when a scancode hits a full pending latch
// Build option: SCANMATRIX_CPU_ACCESS_EN makes the keymap a CPU-accessible
// RAM; otherwise the keymap is the built-in ROM and the CPU pins are inert.
module scancode_to_matrix
    import scanmatrix_pkg::*;
#(
    parameter int SLOTS = 2,
    parameter int ROWS  = 8,
    parameter int COLS  = 5,
    parameter int CNT_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            scan_received,
    input  logic [6:0]      scan,
    input  logic            extended,
    input  logic            released,
    input  logic [2:0]      modifiers,
    input  logic            clear_all,
    input  logic [ROWS-1:0] sp_row,
    output logic [COLS-1:0] sp_col,
    input  logic [7:0]      din,
    output logic [7:0]      dout,
    input  logic            cpuread,
    input  logic            cpuwrite,
    input  logic            rewind,
    output logic            scan_dropped
);

    localparam int SLOT_W = (SLOTS == 4) ? 2 : 1;

    state_t                 state_r, state_s;
    scan_code_t             in_code_s, pend_code_r, cur_code_r;
    logic                   pend_valid_r, clear_req_r, dropped_r;
    logic                   take_pend_s, take_new_s;
    act_t                   act_s, act_r;
    press_ent_t             press_tbl_r [PRESS_DEPTH];
    press_ent_t             press_rd_s;
    logic [MOD_W-1:0]       lk_mods_s;
    logic [KEYMAP_AW-1:0]   map_addr_r;
    logic [SLOT_W-1:0]      slot_r;
    logic [ENTRY_W-1:0]     ent_s;
    logic [ROWS*COLS-1:0]   pressed_s;
    logic [COLS-1:0]        col_s;
    logic [PRESS_AW-1:0]    press_idx_s;

    assign in_code_s   = {modifiers, extended, released, scan};
    assign press_idx_s = {cur_code_r.ext, cur_code_r.scan};

`ifdef SCANMATRIX_CPU_ACCESS_EN
    localparam int CPUADDR_W = KEYMAP_AW + SLOT_W;
    logic [ENTRY_W-1:0]   keymap_mem [SLOTS][KEYMAP_DEPTH];
    logic [CPUADDR_W-1:0] cpuaddr_r;
    logic [7:0]           dout_r;
    logic                 rewind_s, inc_addr_s;
    logic [SLOT_W-1:0]    cpu_slot_s;
    logic [KEYMAP_AW-1:0] cpu_entry_s;

    assign cpu_slot_s  = cpuaddr_r[SLOT_W-1:0];
    assign cpu_entry_s = cpuaddr_r[CPUADDR_W-1:SLOT_W];
    assign ent_s       = keymap_mem[slot_r][map_addr_r];
    assign dout        = dout_r;
`else
    logic unused_cpu_s;
    assign unused_cpu_s = ^{din, cpuread, cpuwrite, rewind};
    assign ent_s        = keymap_rom(2'(slot_r), map_addr_r);
    assign dout         = 8'h00;
`endif

    // Press-table lookup: decide whether this code changes the matrix and
    // which modifier set addresses the keymap (stored ones on release).
    always_comb begin
        press_rd_s = press_tbl_r[press_idx_s];
        act_s      = ACT_NONE;
        lk_mods_s  = cur_code_r.mods;
        if (!cur_code_r.rel && !press_rd_s.valid) begin
            act_s = ACT_INC;
        end else if (cur_code_r.rel && press_rd_s.valid) begin
            act_s     = ACT_DEC;
            lk_mods_s = press_rd_s.mods;
        end else begin
            act_s = ACT_NONE;
        end
    end

    // Next-state logic and IDLE arbitration.
    always_comb begin
        state_s     = state_r;
        take_pend_s = 1'b0;
        take_new_s  = 1'b0;
`ifdef SCANMATRIX_CPU_ACCESS_EN
        rewind_s    = 1'b0;
        inc_addr_s  = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (clear_all || clear_req_r) begin
                    state_s = ST_CLEAR;
                end else if (pend_valid_r) begin
                    state_s     = ST_LOOKUP;
                    take_pend_s = 1'b1;
                end else if (scan_received) begin
                    // Direct path keeps the latch free for a follow-up code.
                    state_s    = ST_LOOKUP;
                    take_new_s = 1'b1;
`ifdef SCANMATRIX_CPU_ACCESS_EN
                end else if (rewind) begin
                    rewind_s = 1'b1;
                end else if (cpuread || cpuwrite) begin
                    state_s = ST_CPUTIME;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOOKUP: state_s = (act_s == ACT_NONE) ? ST_IDLE : ST_APPLY;
            ST_APPLY: begin
                if (slot_r == SLOT_W'(SLOTS - 1)) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_APPLY;
                end
            end
            ST_CLEAR: state_s = ST_IDLE;
`ifdef SCANMATRIX_CPU_ACCESS_EN
            ST_CPUTIME: begin
                if (cpuwrite) begin
                    state_s = ST_CPUWRITE;
                end else if (cpuread) begin
                    state_s = ST_CPUREAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CPUREAD:  state_s = ST_CPUINCADD;
            ST_CPUWRITE: state_s = ST_CPUINCADD;
            ST_CPUINCADD: begin
                if (!cpuread && !cpuwrite) begin
                    state_s    = ST_IDLE;
                    inc_addr_s = 1'b1;
                end else begin
                    state_s = ST_CPUINCADD;
                end
            end
`endif
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Pending latch, current code, clear request and apply sequencing.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid_r <= 1'b0;
            pend_code_r  <= 12'h000;
            cur_code_r   <= 12'h000;
            clear_req_r  <= 1'b0;
            dropped_r    <= 1'b0;
            act_r        <= ACT_NONE;
            map_addr_r   <= 11'h000;
            slot_r       <= {SLOT_W{1'b0}};
        end else begin
            dropped_r <= 1'b0;
            if (take_pend_s) begin
                pend_valid_r <= 1'b0;
            end
            // A latch being drained this cycle can accept the new code.
            if (scan_received && !take_new_s) begin
                if (pend_valid_r && !take_pend_s) begin
                    dropped_r <= 1'b1;
                end else begin
                    pend_valid_r <= 1'b1;
                    pend_code_r  <= in_code_s;
                end
            end
            if (take_pend_s) begin
                cur_code_r <= pend_code_r;
            end else if (take_new_s) begin
                cur_code_r <= in_code_s;
            end
            if (state_s == ST_CLEAR) begin
                clear_req_r <= 1'b0;
            end else if (clear_all) begin
                clear_req_r <= 1'b1;
            end
            if (state_r == ST_LOOKUP) begin
                act_r      <= act_s;
                map_addr_r <= {lk_mods_s, cur_code_r.ext, cur_code_r.scan};
                slot_r     <= {SLOT_W{1'b0}};
            end else if (state_r == ST_APPLY) begin
                slot_r <= slot_r + SLOT_W'(1);
            end
        end
    end

    // Press table: valid bit plus the modifiers captured at make time.
    always_ff @(posedge clk) begin
        if (rst || (state_r == ST_CLEAR)) begin
            for (int i = 0; i < PRESS_DEPTH; i++) begin
                press_tbl_r[i] <= 4'h0;
            end
        end else if ((state_r == ST_LOOKUP) && (act_s == ACT_INC)) begin
            press_tbl_r[press_idx_s] <= {1'b1, cur_code_r.mods};
        end else if ((state_r == ST_LOOKUP) && (act_s == ACT_DEC)) begin
            press_tbl_r[press_idx_s] <= {1'b0, press_rd_s.mods};
        end
    end

`ifdef SCANMATRIX_CPU_ACCESS_EN
    // CPU address pointer and read-data register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpuaddr_r <= {CPUADDR_W{1'b0}};
            dout_r    <= 8'h00;
        end else begin
            if (rewind_s) begin
                cpuaddr_r <= {CPUADDR_W{1'b0}};
            end else if (inc_addr_s) begin
                cpuaddr_r <= cpuaddr_r + CPUADDR_W'(1);
            end
            if (state_r == ST_CPUREAD) begin
                dout_r <= keymap_mem[cpu_slot_s][cpu_entry_s];
            end
        end
    end

    // Keymap RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (state_r == ST_CPUWRITE) begin
            keymap_mem[cpu_slot_s][cpu_entry_s] <= din;
        end
    end
`endif

    // One reference counter per matrix position; entries with row >= ROWS
    // never match a generated row and therefore press nothing.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic hit_s;
            assign hit_s = (state_r == ST_APPLY) && (ent_s[7:5] == ROW_W'(r)) && ent_s[c];
            scanmatrix_refcnt #(.CNT_W(CNT_W)) u_cnt (
                .clk     (clk),
                .rst     (rst),
                .clr     (state_r == ST_CLEAR),
                .inc     (hit_s && (act_r == ACT_INC)),
                .dec     (hit_s && (act_r == ACT_DEC)),
                .nonzero (pressed_s[r*COLS + c])
            );
        end
    end

    // Column data: AND of every selected half-row, low where a key is held.
    always_comb begin
        col_s = {COLS{1'b1}};
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                col_s[c] = col_s[c] & ~(~sp_row[r] & pressed_s[r*COLS + c]);
            end
        end
    end

    assign sp_col       = col_s;
    assign scan_dropped = dropped_r;

endmodule

// File: tb/tb_scancode_to_matrix.sv
// Directed bench for scancode_to_matrix (default parameters). Inputs change
// 1 time unit after the rising edge; outputs are sampled mid-cycle.
module tb_scancode_to_matrix;

    logic       clk = 1'b0;
    logic       rst;
    logic       scan_received;
    logic [6:0] scan;
    logic       extended;
    logic       released;
    logic [2:0] modifiers;
    logic       clear_all;
    logic [7:0] sp_row;
    logic [4:0] sp_col;
    logic [7:0] din;
    logic [7:0] dout;
    logic       cpuread;
    logic       cpuwrite;
    logic       rewind;
    logic       scan_dropped;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    scancode_to_matrix dut (
        .clk           (clk),
        .rst           (rst),
        .scan_received (scan_received),
        .scan          (scan),
        .extended      (extended),
        .released      (released),
        .modifiers     (modifiers),
        .clear_all     (clear_all),
        .sp_row        (sp_row),
        .sp_col        (sp_col),
        .din           (din),
        .dout          (dout),
        .cpuread       (cpuread),
        .cpuwrite      (cpuwrite),
        .rewind        (rewind),
        .scan_dropped  (scan_dropped)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_code(input logic [6:0] s, input logic e, input logic r, input logic [2:0] m);
        scan          = s;
        extended      = e;
        released      = r;
        modifiers     = m;
        scan_received = 1'b1;
    endtask

    task automatic strobe(input logic [6:0] s, input logic e, input logic r, input logic [2:0] m);
        set_code(s, e, r, m);
        tick(1);
        scan_received = 1'b0;
    endtask

    // Strobe and give the FSM time to finish the update.
    task automatic send_key(input logic [6:0] s, input logic e, input logic r, input logic [2:0] m);
        strobe(s, e, r, m);
        tick(6);
    endtask

    task automatic check_row(input string tag, input int row, input logic [4:0] exp);
        sp_row = ~(8'h01 << row);
        #2;
        check_eq(tag, {27'd0, sp_col}, {27'd0, exp});
        sp_row = 8'hFF;
    endtask

    task automatic check_all_rows(input string tag, input logic [4:0] exp);
        sp_row = 8'h00;
        #2;
        check_eq(tag, {27'd0, sp_col}, {27'd0, exp});
        sp_row = 8'hFF;
    endtask

`ifdef SCANMATRIX_CPU_ACCESS_EN
    // Bench copy of the keymap, addressed {entry, slot}.
    function automatic logic [7:0] tb_map(input int a);
        case (a)
            32'h038: return 8'h21;
            32'h034, 32'h044, 32'h042, 32'h046: return 8'h01;
            32'h02C: return 8'h64;
            32'h22C: return 8'h42;
            32'h02A: return 8'h8C;
            32'h138: return 8'hF0;
            32'h02B: return 8'hA1;
            32'h22D: return 8'h10;
            default: return 8'h00;
        endcase
    endfunction

    task automatic cpu_write(input logic [7:0] v);
        din = v;
        cpuwrite = 1'b1;
        tick(4);
        cpuwrite = 1'b0;
        tick(3);
    endtask

    task automatic cpu_read();
        cpuread = 1'b1;
        tick(4);
        cpuread = 1'b0;
        tick(3);
    endtask

    task automatic cpu_rewind();
        rewind = 1'b1;
        tick(1);
        rewind = 1'b0;
        tick(1);
    endtask
`endif

    initial begin
        rst = 1'b1; scan_received = 1'b0; scan = 7'h00; extended = 1'b0;
        released = 1'b0; modifiers = 3'b000; clear_all = 1'b0; sp_row = 8'hFF;
        din = 8'h00; cpuread = 1'b0; cpuwrite = 1'b0; rewind = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);

        // Reset state
        check_all_rows("reset_cols", 5'h1F);
        check_eq("reset_dout", {24'd0, dout}, 32'h0);
        check_eq("reset_drop", {31'd0, scan_dropped}, 32'h0);

`ifdef SCANMATRIX_CPU_ACCESS_EN
        for (int a = 0; a <= 32'h22D; a++) begin
            cpu_write(tb_map(a));
        end
`endif

        // Latency: 0x15 hits row4 in slot0 and row5 in slot1
        strobe(7'h15, 1'b0, 1'b0, 3'b000);
        tick(2);
        check_row("lat_c3_row4", 4, 5'h13);
        check_row("lat_c3_row5", 5, 5'h1F);
        tick(1);
        check_row("lat_c4_row5", 5, 5'h1E);
        tick(4);
        send_key(7'h15, 1'b0, 1'b1, 3'b000);
        check_row("rel15_row4", 4, 5'h1F);
        check_row("rel15_row5", 5, 5'h1F);

        // 0x1C make at cycle 4, then break
        strobe(7'h1C, 1'b0, 1'b0, 3'b000);
        tick(3);
        check_row("p1c_c4", 1, 5'h1E);
        tick(4);
        send_key(7'h1C, 1'b0, 1'b1, 3'b000);
        check_row("r1c", 1, 5'h1F);

        // Extended code uses its own keymap entry
        send_key(7'h1C, 1'b1, 1'b0, 3'b000);
        check_row("ext_row7", 7, 5'h0F);
        check_row("ext_row1", 1, 5'h1F);
        send_key(7'h1C, 1'b1, 1'b1, 3'b000);
        check_row("ext_rel", 7, 5'h1F);

        // Shifted make, break after shift released: stored modifiers used
        send_key(7'h16, 1'b0, 1'b0, 3'b001);
        check_row("sh_row2", 2, 5'h1D);
        check_row("sh_row0", 0, 5'h0F);
        check_row("sh_row3", 3, 5'h1F);
        send_key(7'h16, 1'b0, 1'b1, 3'b000);
        check_all_rows("sh_release", 5'h1F);

        // Two codes sharing row0 col0
        send_key(7'h1A, 1'b0, 1'b0, 3'b000);
        send_key(7'h22, 1'b0, 1'b0, 3'b000);
        send_key(7'h1A, 1'b0, 1'b1, 3'b000);
        check_row("share_one_left", 0, 5'h1E);
        send_key(7'h22, 1'b0, 1'b1, 3'b000);
        check_row("share_none", 0, 5'h1F);

        // Counter saturates at 3: four makes, three breaks release the key
        send_key(7'h1A, 1'b0, 1'b0, 3'b000);
        send_key(7'h22, 1'b0, 1'b0, 3'b000);
        send_key(7'h21, 1'b0, 1'b0, 3'b000);
        send_key(7'h23, 1'b0, 1'b0, 3'b000);
        check_row("sat_4_pressed", 0, 5'h1E);
        send_key(7'h1A, 1'b0, 1'b1, 3'b000);
        send_key(7'h22, 1'b0, 1'b1, 3'b000);
        send_key(7'h21, 1'b0, 1'b1, 3'b000);
        check_row("sat_3_released", 0, 5'h1F);
        send_key(7'h23, 1'b0, 1'b1, 3'b000);
        check_row("sat_floor", 0, 5'h1F);

        // Three back-to-back strobes: third one dropped
        set_code(7'h1C, 1'b0, 1'b0, 3'b000);
        tick(1);
        set_code(7'h1A, 1'b0, 1'b0, 3'b000);
        tick(1);
        #2 check_eq("drop_none_2nd", {31'd0, scan_dropped}, 32'h0);
        set_code(7'h16, 1'b0, 1'b0, 3'b000);
        tick(1);
        scan_received = 1'b0;
        #2 check_eq("drop_pulse", {31'd0, scan_dropped}, 32'h1);
        tick(1);
        check_eq("drop_one_cycle", {31'd0, scan_dropped}, 32'h0);
        tick(12);
        check_row("drop_first_applied", 1, 5'h1E);
        check_row("drop_second_applied", 0, 5'h1E);
        check_row("drop_third_lost", 3, 5'h1F);
        send_key(7'h1C, 1'b0, 1'b1, 3'b000);
        send_key(7'h1A, 1'b0, 1'b1, 3'b000);
        send_key(7'h16, 1'b0, 1'b1, 3'b000);
        check_all_rows("drop_cleanup", 5'h1F);

        // Typematic repeat: five makes, one break
        for (int i = 0; i < 5; i++) begin
            send_key(7'h1C, 1'b0, 1'b0, 3'b000);
        end
        check_row("rep_pressed", 1, 5'h1E);
        send_key(7'h1C, 1'b0, 1'b1, 3'b000);
        check_row("rep_released", 1, 5'h1F);

        // clear_all while APPLY is in progress
        strobe(7'h15, 1'b0, 1'b0, 3'b000);
        tick(1);
        clear_all = 1'b1;
        tick(1);
        clear_all = 1'b0;
        tick(8);
        check_all_rows("clr_mid_apply", 5'h1F);
        send_key(7'h15, 1'b0, 1'b0, 3'b000);
        check_row("clr_valid_zeroed", 4, 5'h13);
        send_key(7'h15, 1'b0, 1'b1, 3'b000);
        check_all_rows("clr_final", 5'h1F);

`ifdef SCANMATRIX_CPU_ACCESS_EN
        // Keymap RAM: write 0x11,0x22,0x33,0xA5,0x55 at addresses 0..4
        cpu_rewind();
        cpu_write(8'h11);
        cpu_write(8'h22);
        cpu_write(8'h33);
        cpu_write(8'hA5);
        cpu_write(8'h55);
        cpu_rewind();
        cpu_read();
        check_eq("cpu_rd0", {24'd0, dout}, 32'h11);
        cpu_read();
        check_eq("cpu_rd1", {24'd0, dout}, 32'h22);
        cpu_read();
        check_eq("cpu_rd2", {24'd0, dout}, 32'h33);
        cpu_read();
        check_eq("cpu_rd3", {24'd0, dout}, 32'hA5);
        cpu_read();
        check_eq("cpu_rd4_addr4", {24'd0, dout}, 32'h55);
`else
        // CPU pins are inert without the RAM option
        cpuread = 1'b1;
        rewind = 1'b1;
        tick(4);
        cpuread = 1'b0;
        rewind = 1'b0;
        cpuwrite = 1'b1;
        din = 8'hFF;
        tick(4);
        cpuwrite = 1'b0;
        tick(2);
        check_eq("nocpu_dout", {24'd0, dout}, 32'h0);
        send_key(7'h1C, 1'b0, 1'b0, 3'b000);
        check_row("nocpu_scan_ok", 1, 5'h1E);
        send_key(7'h1C, 1'b0, 1'b1, 3'b000);
        check_row("nocpu_scan_rel", 1, 5'h1F);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
